// File: rtl/hypercall_log_mux.sv
// Multi-channel hypercall log mux: per-channel tryte FIFOs, round-robin frame arbitration onto one AXI-Stream master.
// Optional HCALL_LOG_TLAST_PER_FRAME_EN: tlast only on the terminator beat instead of on every beat.
module hypercall_log_mux #(
  parameter int unsigned P_CHANNELS = 2,
  parameter int unsigned P_DEPTH    = 8,
  parameter int unsigned P_TRYTE_W  = 18,
  parameter logic [6:0]  P_HDR_ID   = 7'b1000001
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [P_CHANNELS*P_TRYTE_W-1:0] s_tdata,
  input  logic [P_CHANNELS-1:0]           s_tlast,
  input  logic [P_CHANNELS-1:0]           s_tvalid,
  output logic [P_CHANNELS-1:0]           s_tready,
  output logic [31:0]                     m_axis_tdata,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            o_busy,
  output logic [3:0]                      o_chan
);

  localparam int unsigned AW = $clog2(P_DEPTH);
  localparam int unsigned CW = (P_CHANNELS > 1) ? $clog2(P_CHANNELS) : 1;
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(P_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    BODY
  } state_t;

  logic [P_TRYTE_W:0] mem       [P_CHANNELS][P_DEPTH];
  logic [AW-1:0]      wr_ptr    [P_CHANNELS];
  logic [AW-1:0]      rd_ptr    [P_CHANNELS];
  logic [AW:0]        count     [P_CHANNELS];
  logic [AW:0]        frame_cnt [P_CHANNELS];

  logic [P_CHANNELS-1:0] push, pop, full, empty, eligible;
  logic [CW-1:0]         sel;
  logic [P_TRYTE_W:0]    head;
  logic                  body_valid;
  logic                  grant_found;
  logic [3:0]            grant_chan;
  logic [4:0]            cand;
  logic [3:0]            rr_ptr;
  state_t                state;

  always_comb begin
    for (int unsigned c = 0; c < P_CHANNELS; c++) begin
      full[c]     = (count[c] == CNT_FULL);
      empty[c]    = (count[c] == '0);
      eligible[c] = (frame_cnt[c] != '0) || full[c];
      push[c]     = s_tvalid[c] && !full[c];
    end
  end

  assign s_tready = ~full;

  assign sel        = o_chan[CW-1:0];
  assign head       = mem[sel][rd_ptr[sel]];
  assign body_valid = (state == BODY) && !empty[sel];

  always_comb begin
    pop = '0;
    if (body_valid && m_axis_tready) pop[sel] = 1'b1;
  end

  // Search starts one past the last grant so every channel gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_chan  = '0;
    cand        = '0;
    for (int unsigned i = 1; i <= P_CHANNELS; i++) begin
      cand = {1'b0, rr_ptr} + 5'(i);
      if (cand >= 5'(P_CHANNELS)) cand = cand - 5'(P_CHANNELS);
      if (!grant_found && eligible[cand[CW-1:0]]) begin
        grant_found = 1'b1;
        grant_chan  = cand[3:0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int unsigned c = 0; c < P_CHANNELS; c++) begin
      if (push[c]) mem[c][wr_ptr[c]] <= {s_tlast[c], s_tdata[c*P_TRYTE_W +: P_TRYTE_W]};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned c = 0; c < P_CHANNELS; c++) begin
        wr_ptr[c]    <= '0;
        rd_ptr[c]    <= '0;
        count[c]     <= '0;
        frame_cnt[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < P_CHANNELS; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + PTR_ONE;
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + PTR_ONE;
        if (push[c] && !pop[c])      count[c] <= count[c] + CNT_ONE;
        else if (!push[c] && pop[c]) count[c] <= count[c] - CNT_ONE;
        if ((push[c] && s_tlast[c]) && !(pop[c] && head[P_TRYTE_W]))
          frame_cnt[c] <= frame_cnt[c] + CNT_ONE;
        else if (!(push[c] && s_tlast[c]) && (pop[c] && head[P_TRYTE_W]))
          frame_cnt[c] <= frame_cnt[c] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      o_chan <= '0;
      o_busy <= 1'b0;
      rr_ptr <= 4'(P_CHANNELS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            state  <= HEADER;
            o_chan <= grant_chan;
            rr_ptr <= grant_chan;
            o_busy <= 1'b1;
          end
        end
        HEADER: begin
          if (m_axis_tready) state <= BODY;
        end
        BODY: begin
          if (pop[sel] && head[P_TRYTE_W]) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  // Beat is presented straight from the FIFO head, so data stays stable until the pop.
  always_comb begin
    m_axis_tvalid = (state == HEADER) || body_valid;
    m_axis_tdata  = '0;
    if (state == HEADER)
      m_axis_tdata = {16'h0, 4'h0, o_chan, 1'b0, P_HDR_ID};
    else if (body_valid)
      m_axis_tdata = {{(32-P_TRYTE_W){1'b0}}, head[P_TRYTE_W-1:0]};
`ifdef HCALL_LOG_TLAST_PER_FRAME_EN
    m_axis_tlast = body_valid && head[P_TRYTE_W];
`else
    m_axis_tlast = m_axis_tvalid;
`endif
  end

endmodule

// File: tb/tb_hypercall_log_mux.sv
// Self-checking bench for hypercall_log_mux: queue-based reference model compared every cycle,
// plus literal beat sequences for the directed scenarios.
module tb_hypercall_log_mux;

  localparam int CH    = 2;
  localparam int DEPTH = 8;
  localparam int TW    = 18;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [CH*TW-1:0]  s_tdata = '0;
  logic [CH-1:0]     s_tlast = '0;
  logic [CH-1:0]     s_tvalid = '0;
  logic [CH-1:0]     s_tready;
  logic [31:0]       m_axis_tdata;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic              o_busy;
  logic [3:0]        o_chan;

  hypercall_log_mux #(
    .P_CHANNELS(CH),
    .P_DEPTH(DEPTH),
    .P_TRYTE_W(TW),
    .P_HDR_ID(7'b1000001)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .s_tdata(s_tdata),
    .s_tlast(s_tlast),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .o_busy(o_busy),
    .o_chan(o_chan)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: FIFO contents as queues, frame phase 0=idle 1=header 2=body.
  logic [18:0] mq   [CH][$];
  logic [18:0] pend [CH][$];
  int          ph;
  int          cur;
  int          last_g;

  logic [32:0] dut_beats [$];
  logic [32:0] exp_beats [$];
  bit          gen_on;
  int          vprob;
  bit          saw_full1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit tlast_for(input bit is_term);
`ifdef HCALL_LOG_TLAST_PER_FRAME_EN
    return is_term;
`else
    return 1'b1;
`endif
  endfunction

  function automatic int frames_in(input int c);
    int n = 0;
    for (int i = 0; i < mq[c].size(); i++) if (mq[c][i][18]) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      mq[c].delete();
      pend[c].delete();
    end
    ph = 0;
    cur = 0;
    last_g = CH - 1;
  endtask

  task automatic check_outputs();
    bit          ev;
    logic [31:0] ed;
    bit          el;
    logic [CH-1:0] er;
    ev = (ph == 1) || (ph == 2 && mq[cur].size() > 0);
    ed = 32'h0;
    el = 1'b0;
    if (ph == 1) begin
      ed = 32'h41 | (32'(cur) << 8);
      el = tlast_for(1'b0);
    end else if (ev) begin
      ed = {14'h0, mq[cur][0][17:0]};
      el = tlast_for(mq[cur][0][18]);
    end
    for (int c = 0; c < CH; c++) er[c] = (mq[c].size() < DEPTH);
    chk("tvalid", 32'(m_axis_tvalid), 32'(ev));
    if (ev) begin
      chk("tdata", m_axis_tdata, ed);
      chk("tlast", 32'(m_axis_tlast), 32'(el));
    end
    chk("busy", 32'(o_busy), 32'(ph != 0));
    chk("chan", 32'(o_chan), 32'(cur));
    chk("s_tready", 32'(s_tready), 32'(er));
    if (!s_tready[1]) saw_full1 = 1'b1;
  endtask

  task automatic model_step(output logic [CH-1:0] acc);
    logic [CH-1:0] elig;
    logic [18:0]   popped;
    bit            did_pop;
    popped = '0;
    for (int c = 0; c < CH; c++) begin
      elig[c] = (frames_in(c) > 0) || (mq[c].size() == DEPTH);
      acc[c]  = s_tvalid[c] && (mq[c].size() < DEPTH);
    end
    did_pop = (ph == 2) && (mq[cur].size() > 0) && m_axis_tready;
    if (did_pop) popped = mq[cur].pop_front();
    for (int c = 0; c < CH; c++)
      if (acc[c]) mq[c].push_back({s_tlast[c], s_tdata[c*TW +: TW]});
    case (ph)
      0: begin
        for (int k = 1; k <= CH; k++) begin
          int cand;
          cand = (last_g + k) % CH;
          if (ph == 0 && elig[cand]) begin
            ph = 1;
            cur = cand;
            last_g = cand;
          end
        end
      end
      1: if (m_axis_tready) ph = 2;
      default: if (did_pop && popped[18]) ph = 0;
    endcase
  endtask

  task automatic gen_frame(input int c);
    int len;
    len = ($urandom_range(9) == 0) ? int'($urandom_range(9, 14)) : int'($urandom_range(2, 6));
    pend[c].push_back({1'b0, 18'($urandom_range(0, 8))});
    for (int i = 0; i < len - 2; i++) pend[c].push_back({1'b0, 18'($urandom)});
    pend[c].push_back({1'b1, 18'h0});
  endtask

  task automatic cycle(input logic rdy);
    logic [CH-1:0] acc;
    @(negedge CLK);
    check_outputs();
    for (int c = 0; c < CH; c++) begin
      if (gen_on && pend[c].size() == 0) gen_frame(c);
      if (pend[c].size() > 0 && int'($urandom_range(99)) < vprob) begin
        s_tvalid[c] = 1'b1;
        s_tlast[c]  = pend[c][0][18];
        s_tdata[c*TW +: TW] = pend[c][0][17:0];
      end else begin
        s_tvalid[c] = 1'b0;
        s_tlast[c]  = 1'b0;
        s_tdata[c*TW +: TW] = '0;
      end
    end
    m_axis_tready = rdy;
    if (m_axis_tvalid && rdy) dut_beats.push_back({m_axis_tlast, m_axis_tdata});
    model_step(acc);
    for (int c = 0; c < CH; c++) if (acc[c]) void'(pend[c].pop_front());
  endtask

  task automatic drain();
    int n = 0;
    gen_on = 1'b0;
    while (!(pend[0].size() == 0 && pend[1].size() == 0 && mq[0].size() == 0 &&
             mq[1].size() == 0 && ph == 0) && n < 3000) begin
      cycle(1'b1);
      n++;
    end
    chk("drain_timeout", 32'(n < 3000), 32'd1);
    cycle(1'b1);
    cycle(1'b1);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    s_tvalid = '0;
    s_tlast = '0;
    m_axis_tready = 1'b0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    dut_beats.delete();
    exp_beats.delete();
  endtask

  task automatic add_exp(input logic [31:0] d, input bit is_term);
    exp_beats.push_back({tlast_for(is_term), d});
  endtask

  task automatic check_beats(input string name);
    chk({name, "_count"}, 32'(dut_beats.size()), 32'(exp_beats.size()));
    for (int i = 0; i < exp_beats.size() && i < dut_beats.size(); i++) begin
      chk({name, "_data"}, dut_beats[i][31:0], exp_beats[i][31:0]);
      chk({name, "_last"}, 32'(dut_beats[i][32]), 32'(exp_beats[i][32]));
    end
    dut_beats.delete();
    exp_beats.delete();
  endtask

  initial begin
    int n;
    gen_on = 1'b0;
    vprob = 100;
    saw_full1 = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tdata", m_axis_tdata, 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_ready", 32'(s_tready), 32'b11);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_chan", 32'(o_chan), 32'd0);

    // Single frame on channel 0: level 3, "Hi", terminator.
    pend[0].push_back({1'b0, 18'd3});
    pend[0].push_back({1'b0, 18'h48});
    pend[0].push_back({1'b0, 18'h69});
    pend[0].push_back({1'b1, 18'h0});
    drain();
    add_exp(32'h41, 0); add_exp(32'd3, 0); add_exp(32'h48, 0); add_exp(32'h69, 0); add_exp(32'h0, 1);
    check_beats("t1");

    // Two channels ready together, two rounds: ch0 then ch1 each time.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      pend[0].push_back({1'b0, 18'd5}); pend[0].push_back({1'b1, 18'h0});
      pend[1].push_back({1'b0, 18'd7}); pend[1].push_back({1'b1, 18'h0});
      drain();
      add_exp(32'h41, 0);  add_exp(32'd5, 0); add_exp(32'h0, 1);
      add_exp(32'h141, 0); add_exp(32'd7, 0); add_exp(32'h0, 1);
    end
    check_beats("t2");

    // Long frame on ch1 forces a flush before its terminator arrives.
    do_reset();
    saw_full1 = 1'b0;
    for (int i = 1; i <= 12; i++) pend[1].push_back({(i == 12), 18'(i)});
    drain();
    chk("t4_full_seen", 32'(saw_full1), 32'd1);
    add_exp(32'h141, 0);
    for (int i = 1; i <= 12; i++) add_exp(32'(i), i == 12);
    check_beats("t4");

    // Reset in the middle of a ch0 body.
    do_reset();
    for (int i = 1; i <= 6; i++) pend[0].push_back({(i == 6), 18'(i + 16)});
    n = 0;
    while (!(ph == 2 && dut_beats.size() >= 2) && n < 100) begin
      cycle(1'b1);
      n++;
    end
    chk("t5_reach_body", 32'(n < 100), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    chk("t5_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("t5_busy", 32'(o_busy), 32'd0);
    chk("t5_ready", 32'(s_tready), 32'b11);
    chk("t5_chan", 32'(o_chan), 32'd0);
    s_tvalid = '0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    dut_beats.delete();
    pend[1].push_back({1'b0, 18'd2});
    pend[1].push_back({1'b0, 18'h3ABCD});
    pend[1].push_back({1'b1, 18'h0});
    drain();
    add_exp(32'h141, 0); add_exp(32'd2, 0); add_exp(32'h3ABCD, 0); add_exp(32'h0, 1);
    check_beats("t5");

    // Random traffic, random backpressure then 3-on/3-off backpressure.
    do_reset();
    gen_on = 1'b1;
    vprob = 70;
    for (int i = 0; i < 1500; i++) cycle(int'($urandom_range(99)) < 80);
    for (int i = 0; i < 1500; i++) cycle(((i / 3) % 2) == 0);
    vprob = 100;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
